// File: rtl/muldiv_arbiter_if.sv
// Bundle of both requester channels and the shared multiply/divide unit port.
// The arbiter takes the slave view; whatever drives the requesters and models the unit takes the master view.
interface muldiv_arbiter_if;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [7:0]  req0_op_i;
    logic [31:0] req0_op1_i;
    logic [31:0] req0_op2_i;
    logic        rsp0_valid_o;
    logic [31:0] rsp0_data_o;
    logic        rsp0_err_o;

    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [7:0]  req1_op_i;
    logic [31:0] req1_op1_i;
    logic [31:0] req1_op2_i;
    logic        rsp1_valid_o;
    logic [31:0] rsp1_data_o;
    logic        rsp1_err_o;

    logic [7:0]  md_op_o;
    logic [31:0] md_op1_o;
    logic [31:0] md_op2_o;
    logic [31:0] md_wdata_i;
    logic        md_we_i;
    logic        md_stall_i;
    logic        busy_o;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_op1_i, req0_op2_i,
        output req0_ready_o, rsp0_valid_o, rsp0_data_o, rsp0_err_o,
        input  req1_valid_i, req1_op_i, req1_op1_i, req1_op2_i,
        output req1_ready_o, rsp1_valid_o, rsp1_data_o, rsp1_err_o,
        output md_op_o, md_op1_o, md_op2_o, busy_o,
        input  md_wdata_i, md_we_i, md_stall_i
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_op1_i, req0_op2_i,
        input  req0_ready_o, rsp0_valid_o, rsp0_data_o, rsp0_err_o,
        output req1_valid_i, req1_op_i, req1_op1_i, req1_op2_i,
        input  req1_ready_o, rsp1_valid_o, rsp1_data_o, rsp1_err_o,
        input  md_op_o, md_op1_o, md_op2_o, busy_o,
        output md_wdata_i, md_we_i, md_stall_i
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one M-extension mul/div unit between two requesters,
// with a per-op timeout watchdog and rejection of non-one-hot op encodings.
module muldiv_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    muldiv_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              grant;
    logic              winner;
    logic              accept;
    logic [7:0]        op_q;
    logic [31:0]       op1_q;
    logic [31:0]       op2_q;
    logic [CNT_W-1:0]  wdog;
    logic              op_legal;
    logic              done;
    logic              done_err;
    logic [31:0]       done_data;
    logic [31:0]       rsp0_data_q;
    logic [31:0]       rsp1_data_q;
    logic              rsp0_err_q;
    logic              rsp1_err_q;

    // Both valid: the requester that did not win last time goes first.
    assign winner   = (bus.req0_valid_i && bus.req1_valid_i) ? ~last_grant : bus.req1_valid_i;
    assign accept   = (state == IDLE) && (bus.req0_valid_i || bus.req1_valid_i);
    assign op_legal = (op_q != 8'd0) && ((op_q & (op_q - 8'd1)) == 8'd0);

    // An illegal op spends its BUSY cycle with the unit op forced to zero, so the unit never sees it.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        done_err   = 1'b0;
        done_data  = 32'd0;
        case (state)
            IDLE: begin
                if (accept) state_next = BUSY;
            end
            BUSY: begin
                if (!op_legal) begin
                    state_next = RESP;
                    done       = 1'b1;
                    done_err   = 1'b1;
                end else if (bus.md_we_i) begin
                    state_next = RESP;
                    done       = 1'b1;
                    done_data  = bus.md_wdata_i;
                end else if (wdog == WDOG_LIMIT) begin
                    state_next = RESP;
                    done       = 1'b1;
                    done_err   = 1'b1;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            op_q        <= 8'd0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            wdog        <= '0;
            rsp0_data_q <= 32'd0;
            rsp1_data_q <= 32'd0;
            rsp0_err_q  <= 1'b0;
            rsp1_err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                grant      <= winner;
                last_grant <= winner;
                op_q       <= winner ? bus.req1_op_i  : bus.req0_op_i;
                op1_q      <= winner ? bus.req1_op1_i : bus.req0_op1_i;
                op2_q      <= winner ? bus.req1_op2_i : bus.req0_op2_i;
            end
            wdog <= (state == BUSY) ? wdog + CNT_W'(1) : '0;
            if (done) begin
                if (grant) begin
                    rsp1_data_q <= done_data;
                    rsp1_err_q  <= done_err;
                end else begin
                    rsp0_data_q <= done_data;
                    rsp0_err_q  <= done_err;
                end
            end
        end
    end

    assign bus.req0_ready_o = accept && !winner;
    assign bus.req1_ready_o = accept && winner;
    assign bus.rsp0_valid_o = (state == RESP) && !grant;
    assign bus.rsp1_valid_o = (state == RESP) && grant;
    assign bus.rsp0_data_o  = rsp0_data_q;
    assign bus.rsp1_data_o  = rsp1_data_q;
    assign bus.rsp0_err_o   = rsp0_err_q;
    assign bus.rsp1_err_o   = rsp1_err_q;
    assign bus.md_op_o      = ((state == BUSY) && op_legal) ? op_q : 8'd0;
    assign bus.md_op1_o     = op1_q;
    assign bus.md_op2_o     = op2_q;
    assign bus.busy_o       = (state != IDLE);

endmodule
